d_issue_ctl: RTL and testbench

- Issue controller for the decode stage. It decides each cycle whether the instruction currently presented by fetch leaves decode.
- Keeps a 32-entry register scoreboard of pending writes and stalls decode on RAW/WAW hazards.
- Holds issue after a branch until execute resolves it.
- Sits between fetch, the decoder/register-file pair and execute. It drives decode's accept qualifier and fetch's stall.

---
 rtl/d_issue_ctl_pkg.sv | 13 +
 rtl/d_issue_ctl_scoreboard.sv | 46 ++++
 rtl/d_issue_ctl.sv | 114 +++++++++++
 tb/tb_d_issue_ctl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/d_issue_ctl_pkg.sv
// Shared definitions for the decode issue controller: state encoding, the
// hard-wired zero register and the default stall-counter width.
package d_issue_ctl_pkg;

    typedef enum logic [1:0] {
        ISSUE_RUN     = 2'd0,
        ISSUE_BR_WAIT = 2'd1
    } issue_state_t;

    localparam logic [4:0] REG_X0          = 5'd0;
    localparam int         STALL_CNT_W_DEF = 16;

endpackage

// File: rtl/d_issue_ctl_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, with
// set-wins-over-clear on collisions and x0 never marked busy.
module d_scoreboard
    import d_issue_ctl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        set_en,
    input  logic [4:0]  set_sel,
    input  logic        clr_en,
    input  logic [4:0]  clr_sel,
    input  logic [4:0]  rd_a_sel,
    input  logic [4:0]  rd_b_sel,
    input  logic [4:0]  rd_d_sel,
    output logic        busy_a,
    output logic        busy_b,
    output logic        busy_d,
    output logic [31:0] busy_o
);

    logic [31:0] busy;
    logic [31:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_sel] = 1'b0;
        // Applied after the clear: the newly issued writer is younger.
        if (set_en && (set_sel != REG_X0))
            busy_nxt[set_sel] = 1'b1;
        busy_nxt[REG_X0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign busy_a = busy[rd_a_sel];
    assign busy_b = busy[rd_b_sel];
    assign busy_d = busy[rd_d_sel];
    assign busy_o = busy;

endmodule

// File: rtl/d_issue_ctl.sv
// Decode-stage issue controller: hazard-qualified issue, branch hold until
// execute resolves, saturating stall counter and a sticky branch-wait timeout.
//
//   state         | meaning
//   --------------+------------------------------------------------------
//   ISSUE_RUN     | normal issue, gated by scoreboard hazards and e_ready
//   ISSUE_BR_WAIT | branch issued; hold all issue until br_resolve
module d_issue_ctl
    import d_issue_ctl_pkg::*;
#(
    parameter int STALL_CNT_W = STALL_CNT_W_DEF,
    parameter int BR_TIMEOUT  = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   f_valid,
    input  logic                   rd_a_en,
    input  logic                   rd_b_en,
    input  logic [4:0]             regA,
    input  logic [4:0]             regB,
    input  logic [4:0]             regD,
    input  logic                   w_en,
    input  logic                   is_branch,
    input  logic                   e_ready,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_sel,
    input  logic                   br_resolve,
    output logic                   issue_o,
    output logic                   f_stall_o,
    output logic [31:0]            busy_o,
    output logic [1:0]             state_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   br_timeout_o
);

    localparam int             TO_W   = $clog2(BR_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(BR_TIMEOUT);

    issue_state_t          state;
    issue_state_t          state_nxt;
    logic                  busy_a;
    logic                  busy_b;
    logic                  busy_d;
    logic                  raw;
    logic                  waw;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic [TO_W-1:0]       br_cnt;
    logic                  br_timeout;

    d_scoreboard u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (issue_o & w_en),
        .set_sel  (regD),
        .clr_en   (wb_valid),
        .clr_sel  (wb_sel),
        .rd_a_sel (regA),
        .rd_b_sel (regB),
        .rd_d_sel (regD),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .busy_d   (busy_d),
        .busy_o   (busy_o)
    );

    // Registered busy only: a consumer waits one cycle past its writeback.
    assign raw       = (rd_a_en & busy_a) | (rd_b_en & busy_b);
    assign waw       = w_en & busy_d;
    assign issue_o   = f_valid & e_ready & (state == ISSUE_RUN) & ~raw & ~waw;
    assign f_stall_o = f_valid & ~issue_o;

    always_comb begin
        state_nxt = state;
        case (state)
            ISSUE_RUN:     if (issue_o && is_branch) state_nxt = ISSUE_BR_WAIT;
            ISSUE_BR_WAIT: if (br_resolve)           state_nxt = ISSUE_RUN;
            default:                                 state_nxt = ISSUE_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ISSUE_RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (f_stall_o && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    // Timeout is diagnostic only; the FSM keeps waiting for br_resolve.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            br_cnt     <= '0;
            br_timeout <= 1'b0;
        end else if ((state == ISSUE_BR_WAIT) && !br_resolve) begin
            if (br_cnt != TO_MAX)
                br_cnt <= br_cnt + 1'b1;
            if (br_cnt + 1'b1 == TO_MAX)
                br_timeout <= 1'b1;
        end else begin
            br_cnt <= '0;
        end
    end

    assign state_o      = state;
    assign stall_cnt_o  = stall_cnt;
    assign br_timeout_o = br_timeout;

endmodule

// File: tb/tb_d_issue_ctl.sv
// Directed bench for d_issue_ctl with small timeout and stall-counter sizes
// so timeout and saturation are reachable in a few cycles.
module tb_d_issue_ctl;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_valid, rd_a_en, rd_b_en, w_en, is_branch, e_ready;
    logic        wb_valid, br_resolve;
    logic [4:0]  regA, regB, regD, wb_sel;
    logic        issue_o, f_stall_o, br_timeout_o;
    logic [31:0] busy_o;
    logic [1:0]  state_o;
    logic [3:0]  stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    d_issue_ctl #(.STALL_CNT_W(4), .BR_TIMEOUT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .f_valid      (f_valid),
        .rd_a_en      (rd_a_en),
        .rd_b_en      (rd_b_en),
        .regA         (regA),
        .regB         (regB),
        .regD         (regD),
        .w_en         (w_en),
        .is_branch    (is_branch),
        .e_ready      (e_ready),
        .wb_valid     (wb_valid),
        .wb_sel       (wb_sel),
        .br_resolve   (br_resolve),
        .issue_o      (issue_o),
        .f_stall_o    (f_stall_o),
        .busy_o       (busy_o),
        .state_o      (state_o),
        .stall_cnt_o  (stall_cnt_o),
        .br_timeout_o (br_timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        f_valid = 0; rd_a_en = 0; rd_b_en = 0; w_en = 0; is_branch = 0;
        e_ready = 1; wb_valid = 0; br_resolve = 0;
        regA = 0; regB = 0; regD = 0; wb_sel = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        cyc();
        reset = 1;
        cyc();
    endtask

    initial begin
        // Reset / idle
        idle();
        reset = 0;
        f_valid = 1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_timeout", br_timeout_o, 0);
        reset = 1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            #1 chk("idle_issue", issue_o, 1);
            cyc();
        end
        chk("idle_stall", stall_cnt_o, 0);

        // RAW stall and release one cycle after writeback
        do_reset();
        f_valid = 1; w_en = 1; regD = 5;
        #1 chk("raw_prod_issue", issue_o, 1);
        cyc();
        chk("raw_busy5", busy_o, 32'h20);
        idle(); f_valid = 1; rd_a_en = 1; regA = 5;
        #1 chk("raw_block", issue_o, 0);
        chk("raw_fstall", f_stall_o, 1);
        cyc();
        cyc();
        wb_valid = 1; wb_sel = 5;
        #1 chk("raw_wb_same_cycle", issue_o, 0);
        cyc();
        wb_valid = 0;
        chk("raw_busy_cleared", busy_o, 0);
        #1 chk("raw_release", issue_o, 1);
        chk("raw_stall_cnt", stall_cnt_o, 3);
        cyc();
        // WAW, regB RAW and e_ready stalls
        idle(); f_valid = 1; w_en = 1; regD = 9;
        cyc();
        chk("waw_busy9", busy_o, 32'h200);
        #1 chk("waw_block", issue_o, 0);
        cyc();
        idle(); f_valid = 1; rd_b_en = 1; regB = 9;
        #1 chk("rawb_block", issue_o, 0);
        cyc();
        idle(); f_valid = 1; e_ready = 0;
        #1 chk("eready_block", issue_o, 0);
        cyc();
        chk("stall_cnt_mix", stall_cnt_o, 6);

        // x0 masking, set-wins, harmless writeback
        do_reset();
        f_valid = 1; w_en = 1; regD = 0;
        cyc();
        chk("x0_never_busy", busy_o, 0);
        regD = 7; wb_valid = 1; wb_sel = 7;
        #1 chk("setwin_issue", issue_o, 1);
        cyc();
        chk("set_wins", busy_o, 32'h80);
        idle(); wb_valid = 1; wb_sel = 3;
        cyc();
        chk("wb_nonbusy", busy_o, 32'h80);
        wb_sel = 7;
        cyc();
        chk("wb_clear7", busy_o, 0);

        // Branch sequencing
        do_reset();
        br_resolve = 1;
        cyc();
        chk("resolve_in_run", state_o, 0);
        idle(); f_valid = 1; is_branch = 1;
        #1 chk("br_issue", issue_o, 1);
        cyc();
        chk("br_wait", state_o, 1);
        idle(); f_valid = 1;
        #1 chk("br_hold_issue", issue_o, 0);
        chk("br_hold_fstall", f_stall_o, 1);
        cyc();
        cyc();
        br_resolve = 1;
        #1 chk("br_resolve_cycle", issue_o, 0);
        cyc();
        br_resolve = 0;
        chk("br_back_run", state_o, 0);
        #1 chk("br_resume", issue_o, 1);
        cyc();
        // Hazard-blocked branch stays in RUN
        idle(); f_valid = 1; w_en = 1; regD = 4;
        cyc();
        idle(); f_valid = 1; is_branch = 1; rd_a_en = 1; regA = 4;
        #1 chk("brhaz_block", issue_o, 0);
        cyc();
        chk("brhaz_state_run", state_o, 0);
        wb_valid = 1; wb_sel = 4;
        cyc();
        wb_valid = 0;
        #1 chk("brhaz_issue", issue_o, 1);
        cyc();
        chk("brhaz_state_wait", state_o, 1);

        // Branch timeout
        do_reset();
        f_valid = 1; is_branch = 1;
        cyc();
        idle();
        repeat (3) cyc();
        chk("to_before", br_timeout_o, 0);
        cyc();
        chk("to_set", br_timeout_o, 1);
        repeat (6) cyc();
        chk("to_still_wait", state_o, 1);
        br_resolve = 1;
        cyc();
        br_resolve = 0;
        chk("to_resolved", state_o, 0);
        chk("to_sticky", br_timeout_o, 1);

        // Stall counter saturation
        do_reset();
        f_valid = 1; e_ready = 0;
        repeat (14) cyc();
        chk("sat_14", stall_cnt_o, 14);
        repeat (6) cyc();
        chk("sat_15", stall_cnt_o, 15);

        // Async reset mid-operation
        do_reset();
        f_valid = 1; w_en = 1; regD = 5;
        cyc();
        regD = 6; is_branch = 1;
        cyc();
        idle();
        chk("async_pre_busy", busy_o, 32'h60);
        chk("async_pre_state", state_o, 1);
        #2 reset = 0;
        #1;
        chk("async_busy", busy_o, 0);
        chk("async_state", state_o, 0);
        chk("async_stall", stall_cnt_o, 0);
        chk("async_timeout", br_timeout_o, 0);
        #1 reset = 1;
        cyc();
        f_valid = 1; rd_a_en = 1; regA = 5;
        #1 chk("async_no_pending", issue_o, 1);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
